sink_mem: RTL and testbench
===========================

Name: sink_mem

Overview:
- Per-channel PCM capture buffer: accepts 16-bit samples on a valid/ready stream and writes them to a dual-port RAM.
- Captured data is read back over the 16-bit-address / 32-bit-data register bus, two samples per word.
- Sits at the tail of the processing chain (after ADC/filter) so firmware can fetch echo records.
- Single clock domain: stream and register bus both run on pcm_clk.

Parameters:
- CHANNEL, 3, number of independent capture channels (max 15).
- pcmaw, 10, sample-address width; buffer depth 2^pcmaw samples per channel (max 13).
- DROP_IDLE, 1, 1: pcm_in_ready high in every non-reset state, samples outside CAPTURE discarded; 0: pcm_in_ready high only in CAPTURE.

Ports:
- pcm_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- pcm_in_valid  in  CHANNEL  sample valid per channel.
- pcm_in_ready  out  CHANNEL  sample ready per channel.
- pcm_in  in  16*CHANNEL  channel k sample on bits [16k+15:16k], signed.
- reg_addr  in  16  word address; [15:12] page select.
- reg_rd  in  1  read request, held until reg_ready.
- reg_wr  in  1  write request, held until reg_ready.
- reg_ready  out  1  access completion strobe.
- reg_writedata  in  32  write data.
- reg_readdata  out  32  read data, valid while reg_ready=1.
- capture_len  in  pcmaw*CHANNEL  samples per capture for channel k; 0 disables the channel.
- capture_done  out  CHANNEL  level, high in DONE.

Behaviour:
- Reset values: all channels IDLE, wr_addr=0, capture_done=0, reg_ready=0, reg_readdata=0, pcm_in_ready=0 (DROP_IDLE=0) or 1 after the first post-reset cycle (DROP_IDLE=1). RAM contents are not cleared.
- Per-channel FSM:
  - IDLE: arm → CAPTURE with wr_addr=0.
  - CAPTURE: each handshake (valid & ready) writes pcm_in to RAM[wr_addr], then wr_addr+1. When wr_addr+1 == capture_len → DONE on the same edge that writes the last sample.
  - DONE: arm → CAPTURE (wr_addr=0); clear → IDLE.
  - clear from any state → IDLE, wr_addr=0.
- Arm while in CAPTURE restarts at wr_addr=0; already-written data is left in RAM.
- Arm and clear in the same write: clear wins.
- Arm with capture_len=0: ignored, channel stays IDLE.
- capture_len changed mid-capture: compared live. If wr_addr already exceeds the new value, capture runs to address 2^pcmaw-1, wraps to 0 and continues until equality is reached. Firmware must not do this.
- Maximum record length is 2^pcmaw-1 samples.
- Register handshake:
  - reg_ready toggles every cycle while reg_rd|reg_wr is high; otherwise 0.
  - Access completes on the first cycle reg_ready=1, i.e. 2 cycles per access.
  - Reads: RAM port-B latency 1 cycle; data is registered and presented with reg_ready.
- Memory page, reg_addr[15:12]=k<CHANNEL and reg_addr[11:pcmaw-1]==0 (no range check when pcmaw=13):
  - Read word n returns {sample[2n+1], sample[2n]}.
  - Writes are ignored.
  - Out-of-range addresses read 0.
- Control page, reg_addr[15:12]=4'hF:
  - Word k write: bit0=arm, bit1=clear; single-cycle action on the completing cycle.
  - Word k read: {pcmaw-bit wr_addr zero-extended at [31:16], 14'b0, state[1:0]}.
  - Any other page or word reads 0.
- State encoding: IDLE=0, CAPTURE=1, DONE=2.
- RAM collision: a register read of the word being written in the same cycle returns old data.

Decomposition:
- Package sink_mem_pkg holds:
  - state encoding (ST_IDLE, ST_CAPTURE, ST_DONE);
  - control page (CTRL_PAGE=4'hF);
  - control bits (CTRL_ARM=0, CTRL_CLEAR=1).
- RAM is the existing generic_dpram:
  - port A: 16-bit write-only;
  - port B: 32-bit read-only, pipeline=1;
  - both ports on pcm_clk.
- Natural sub-module: sink_chan (FSM + wr_addr + RAM instance), instantiated CHANNEL times by a generate loop.
- The top level keeps only register decode, read mux and reg_ready.

Test Plan:
- capture_len[0]=8, arm ch0, drive samples 0x0001..0x0008 with valid always high:
  - capture_done[0] rises on the edge of the 8th handshake;
  - reads of 0x0000..0x0003 return 0x00020001, 0x00040003, 0x00060005, 0x00080007;
  - status read shows wr_addr=0, state=2.
- DROP_IDLE=0, channel in IDLE with pcm_in_valid=1: pcm_in_ready=0. After arm, ready=1 from the next cycle; a valid gap of 3 cycles does not advance wr_addr.
- Arm and clear written together (0x3) to ch1 in CAPTURE: state becomes IDLE, wr_addr=0.
- Reset after 5 of 8 samples: all status reads return 0. RAM words 0..1 still return the pre-reset data.
- Read 0xF005 and memory word 0x0200 with pcmaw=10: both return 0. Each access has reg_ready high exactly on its 2nd cycle.
- Channels 0 and 2 capture simultaneously with capture_len 4 and 6: independent done timing, no cross-channel RAM corruption.

Source files
------------

// File: rtl/sink_mem_pkg.sv
// Shared constants for the PCM capture buffer: channel FSM encoding and
// control-page layout.
package sink_mem_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [3:0] CTRL_PAGE  = 4'hF;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_CLEAR = 1;

endpackage

// File: rtl/sink_mem_if.sv
// Sample stream and register bus of the PCM capture buffer, bundled so the
// producer/firmware side and the buffer side see matching directions.
interface sink_mem_if #(
    parameter int CHANNEL = 3
) ();

    logic [CHANNEL-1:0]    pcm_in_valid;
    logic [CHANNEL-1:0]    pcm_in_ready;
    logic [16*CHANNEL-1:0] pcm_in;
    logic [15:0]           reg_addr;
    logic                  reg_rd;
    logic                  reg_wr;
    logic                  reg_ready;
    logic [31:0]           reg_writedata;
    logic [31:0]           reg_readdata;

    modport master (
        output pcm_in_valid, pcm_in, reg_addr, reg_rd, reg_wr, reg_writedata,
        input  pcm_in_ready, reg_ready, reg_readdata
    );

    modport slave (
        input  pcm_in_valid, pcm_in, reg_addr, reg_rd, reg_wr, reg_writedata,
        output pcm_in_ready, reg_ready, reg_readdata
    );

endinterface

// File: rtl/generic_dpram.sv
// Dual-port RAM: 16-bit write-only port A, 32-bit read-only port B returning
// two adjacent 16-bit entries (odd entry in the upper half).
module generic_dpram #(
    parameter int AW       = 10,
    parameter int PIPELINE = 1
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [15:0]   a_wdata,
    input  logic [AW-2:0] b_addr,
    output logic [31:0]   b_rdata
);

    logic [15:0] mem [2**AW];
    logic [31:0] b_rdata_d;

    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
    end

    assign b_rdata_d = {mem[{b_addr, 1'b1}], mem[{b_addr, 1'b0}]};

    // Registered read samples before the same-edge write, so a colliding read sees old data.
    generate
        if (PIPELINE != 0) begin : g_pipe
            logic [31:0] b_rdata_q;
            always_ff @(posedge clk) b_rdata_q <= b_rdata_d;
            assign b_rdata = b_rdata_q;
        end else begin : g_comb
            assign b_rdata = b_rdata_d;
        end
    endgenerate

endmodule

// File: rtl/sink_mem_chan.sv
// One capture channel: arm/clear FSM, sample write pointer and its RAM.
//   state      | meaning
//   ST_IDLE    | not capturing, waiting for arm
//   ST_CAPTURE | writing accepted samples at wr_addr
//   ST_DONE    | capture_len samples stored, waiting for arm or clear
module sink_chan
    import sink_mem_pkg::*;
#(
    parameter int pcmaw     = 10,
    parameter int DROP_IDLE = 1
) (
    input  logic             pcm_clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             clear,
    input  logic [pcmaw-1:0] capture_len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    input  logic [pcmaw-2:0] rd_addr,
    output logic [31:0]      rd_data,
    output logic [1:0]       state,
    output logic [pcmaw-1:0] wr_addr,
    output logic             done
);

    logic [1:0]       state_q, state_d;
    logic [pcmaw-1:0] wr_addr_q, wr_addr_d;
    logic [pcmaw-1:0] addr_inc;
    logic             hs;
    logic             arm_ok;

    assign hs       = in_valid & in_ready & (state_q == ST_CAPTURE);
    assign arm_ok   = arm & (capture_len != '0);
    assign addr_inc = wr_addr_q + pcmaw'(1);

    // Length is compared live; the increment wraps naturally at 2^pcmaw.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        if (clear) begin
            state_d   = ST_IDLE;
            wr_addr_d = '0;
        end else if (arm_ok) begin
            state_d   = ST_CAPTURE;
            wr_addr_d = '0;
        end else if (hs) begin
            if (addr_inc == capture_len) begin
                state_d   = ST_DONE;
                wr_addr_d = '0;
            end else begin
                wr_addr_d = addr_inc;
            end
        end
    end

    always_ff @(posedge pcm_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    generate
        if (DROP_IDLE != 0) begin : g_drop
            logic ready_q, ready_d;
            assign ready_d = 1'b1;
            always_ff @(posedge pcm_clk) begin
                if (rst) ready_q <= 1'b0;
                else     ready_q <= ready_d;
            end
            assign in_ready = ready_q;
        end else begin : g_hold
            assign in_ready = (state_q == ST_CAPTURE);
        end
    endgenerate

    generic_dpram #(.AW(pcmaw), .PIPELINE(1)) u_ram (
        .clk     (pcm_clk),
        .a_we    (hs),
        .a_addr  (wr_addr_q),
        .a_wdata (in_data),
        .b_addr  (rd_addr),
        .b_rdata (rd_data)
    );

    assign state   = state_q;
    assign wr_addr = wr_addr_q;
    assign done    = (state_q == ST_DONE);

endmodule

// File: rtl/sink_mem.sv
// PCM capture buffer top: register decode, read mux and the two-cycle
// reg_ready handshake around CHANNEL capture channels.
module sink_mem
    import sink_mem_pkg::*;
#(
    parameter int CHANNEL   = 3,
    parameter int pcmaw     = 10,
    parameter int DROP_IDLE = 1
) (
    input  logic                     pcm_clk,
    input  logic                     rst,
    sink_mem_if.slave                bus,
    input  logic [pcmaw*CHANNEL-1:0] capture_len,
    output logic [CHANNEL-1:0]       capture_done
);

    localparam logic [3:0]  CH_PAGES = 4'(CHANNEL);
    localparam logic [11:0] CH_WORDS = 12'(CHANNEL);

    logic               reg_ready_q, reg_ready_d;
    logic [3:0]         page;
    logic [11:0]        word;
    logic               in_range;
    logic               mem_sel;
    logic               ctrl_sel;
    logic               ctrl_wr;
    logic [31:0]        rd_mux;
    logic [CHANNEL-1:0] arm;
    logic [CHANNEL-1:0] clear;
    logic [CHANNEL-1:0] in_ready;
    logic [31:0]        chan_rdata   [CHANNEL];
    logic [1:0]         chan_state   [CHANNEL];
    logic [pcmaw-1:0]   chan_wr_addr [CHANNEL];
    logic               unused_wdata;

    assign page = bus.reg_addr[15:12];
    assign word = bus.reg_addr[11:0];

    // Address bits above the per-channel word range must be zero.
    always_comb begin
        in_range = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i >= pcmaw - 1 && bus.reg_addr[i]) in_range = 1'b0;
        end
    end

    assign mem_sel  = (page < CH_PAGES) && in_range;
    assign ctrl_sel = (page == CTRL_PAGE) && (word < CH_WORDS);
    assign ctrl_wr  = bus.reg_wr & reg_ready_q & ctrl_sel;

    assign reg_ready_d = (bus.reg_rd | bus.reg_wr) & ~reg_ready_q;

    always_ff @(posedge pcm_clk) begin
        if (rst) reg_ready_q <= 1'b0;
        else     reg_ready_q <= reg_ready_d;
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < CHANNEL; k++) begin
            if (mem_sel && page == 4'(k)) rd_mux = chan_rdata[k];
            if (ctrl_sel && word == 12'(k))
                rd_mux = {{(16 - pcmaw){1'b0}}, chan_wr_addr[k], 14'b0, chan_state[k]};
        end
    end

    assign bus.reg_ready    = reg_ready_q;
    assign bus.reg_readdata = reg_ready_q ? rd_mux : '0;
    assign bus.pcm_in_ready = in_ready;
    assign unused_wdata     = ^bus.reg_writedata[31:2];

    generate
        for (genvar k = 0; k < CHANNEL; k++) begin : g_chan
            assign arm[k]   = ctrl_wr && (word == 12'(k)) && bus.reg_writedata[CTRL_ARM];
            assign clear[k] = ctrl_wr && (word == 12'(k)) && bus.reg_writedata[CTRL_CLEAR];

            sink_chan #(.pcmaw(pcmaw), .DROP_IDLE(DROP_IDLE)) u_chan (
                .pcm_clk     (pcm_clk),
                .rst         (rst),
                .arm         (arm[k]),
                .clear       (clear[k]),
                .capture_len (capture_len[k*pcmaw +: pcmaw]),
                .in_valid    (bus.pcm_in_valid[k]),
                .in_data     (bus.pcm_in[16*k +: 16]),
                .in_ready    (in_ready[k]),
                .rd_addr     (bus.reg_addr[pcmaw-2:0]),
                .rd_data     (chan_rdata[k]),
                .state       (chan_state[k]),
                .wr_addr     (chan_wr_addr[k]),
                .done        (capture_done[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sink_mem.sv
// Directed bench for sink_mem: dut0 holds ready low outside capture,
// dut1 accepts and drops samples while not capturing.
module tb_sink_mem;

    logic        pcm_clk = 1'b0;
    logic        rst     = 1'b1;
    logic [29:0] cap_len0 = '0;
    logic [29:0] cap_len1 = {10'd4, 10'd4, 10'd4};
    logic [2:0]  done0;
    logic [2:0]  done1;
    int          checks = 0;
    int          errors = 0;

    sink_mem_if #(.CHANNEL(3)) bus0 ();
    sink_mem_if #(.CHANNEL(3)) bus1 ();

    sink_mem #(.CHANNEL(3), .pcmaw(10), .DROP_IDLE(0)) dut0 (
        .pcm_clk(pcm_clk), .rst(rst), .bus(bus0), .capture_len(cap_len0), .capture_done(done0));

    sink_mem #(.CHANNEL(3), .pcmaw(10), .DROP_IDLE(1)) dut1 (
        .pcm_clk(pcm_clk), .rst(rst), .bus(bus1), .capture_len(cap_len1), .capture_done(done1));

    always #5 pcm_clk = ~pcm_clk;

    task automatic bus_set(input bit sel, input logic [15:0] a, input logic rd,
                           input logic wr, input logic [31:0] d);
        if (sel) begin
            bus1.reg_addr = a; bus1.reg_rd = rd; bus1.reg_wr = wr; bus1.reg_writedata = d;
        end else begin
            bus0.reg_addr = a; bus0.reg_rd = rd; bus0.reg_wr = wr; bus0.reg_writedata = d;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? bus1.reg_ready : bus0.reg_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus1.reg_readdata : bus0.reg_readdata;
    endfunction

    // Read with the request held through the completing edge; timing_ok means
    // reg_ready was 0 in cycle 1, 1 in cycle 2 and 0 afterwards.
    task automatic reg_read(input bit sel, input logic [15:0] a,
                            output logic [31:0] d, output bit timing_ok);
        logic r_before, r_after;
        bit   got;
        int   n;
        got = 0; n = 0; d = 32'hDEAD_BEEF;
        @(negedge pcm_clk);
        bus_set(sel, a, 1'b1, 1'b0, 32'h0);
        #1 r_before = get_ready(sel);
        while (!got && n < 4) begin
            @(posedge pcm_clk); #1;
            n++;
            if (get_ready(sel)) begin
                got = 1;
                d   = get_rdata(sel);
            end
        end
        @(posedge pcm_clk); #1 r_after = get_ready(sel);
        @(negedge pcm_clk);
        bus_set(sel, a, 1'b0, 1'b0, 32'h0);
        timing_ok = got && (n == 1) && !r_before && !r_after;
    endtask

    task automatic reg_write(input bit sel, input logic [15:0] a, input logic [31:0] d);
        bit got;
        int n;
        got = 0; n = 0;
        @(negedge pcm_clk);
        bus_set(sel, a, 1'b0, 1'b1, d);
        while (!got && n < 4) begin
            @(posedge pcm_clk); #1;
            n++;
            if (get_ready(sel)) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL write_ready addr %h: reg_ready never rose, required within 1 cycle", a);
        end
        @(posedge pcm_clk);
        @(negedge pcm_clk);
        bus_set(sel, a, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit          t;
        repeat (3) @(negedge pcm_clk);
        checks++;
        if ({done0, bus0.reg_ready, bus0.pcm_in_ready, bus1.pcm_in_ready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {done0, bus0.reg_ready, bus0.pcm_in_ready, bus1.pcm_in_ready});
        end
        checks++;
        if (bus0.reg_readdata !== 32'h0) begin
            errors++; $display("FAIL reset_readdata: got %h required 00000000", bus0.reg_readdata);
        end
        rst = 1'b0;
        @(posedge pcm_clk); #1;
        checks++;
        if (bus1.pcm_in_ready !== 3'b111 || bus0.pcm_in_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_after: got drop=%b hold=%b required 111 000",
                     bus1.pcm_in_ready, bus0.pcm_in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            reg_read(0, 16'hF000 + 16'(k), d, t);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL reset_status%0d: got %h required 00000000", k, d); end
        end
    endtask

    task automatic test_capture();
        logic [31:0] d;
        logic [31:0] exp_w [4];
        bit          t;
        exp_w = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
        cap_len0[9:0] = 10'd8;
        reg_write(0, 16'hF000, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge pcm_clk);
            bus0.pcm_in_valid[0] = 1'b1;
            bus0.pcm_in[15:0]    = 16'(i);
            @(posedge pcm_clk); #1;
            checks++;
            if (done0[0] !== (i == 8)) begin
                errors++; $display("FAIL capture_done_edge%0d: got %b required %b", i, done0[0], (i == 8));
            end
        end
        @(negedge pcm_clk);
        bus0.pcm_in_valid[0] = 1'b0;
        for (int n = 0; n < 4; n++) begin
            reg_read(0, 16'(n), d, t);
            checks++;
            if (d !== exp_w[n] || !t) begin
                errors++; $display("FAIL capture_word%0d: got %h timing %0d required %h timing 1", n, d, t, exp_w[n]);
            end
        end
        reg_read(0, 16'hF000, d, t);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL capture_status: got %h required 00000002", d); end
    endtask

    task automatic test_ready_gating();
        logic [31:0] d;
        bit          t;
        cap_len0[19:10] = 10'd8;
        @(negedge pcm_clk);
        bus0.pcm_in_valid[1] = 1'b1;
        bus0.pcm_in[31:16]   = 16'h5555;
        @(posedge pcm_clk); #1;
        checks++;
        if (bus0.pcm_in_ready[1] !== 1'b0) begin
            errors++; $display("FAIL idle_ready: got %b required 0", bus0.pcm_in_ready[1]);
        end
        @(negedge pcm_clk);
        bus0.pcm_in_valid[1] = 1'b0;
        reg_write(0, 16'hF001, 32'h1);
        checks++;
        if (bus0.pcm_in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL armed_ready: got %b required 1", bus0.pcm_in_ready[1]);
        end
        for (int i = 1; i <= 2; i++) begin
            bus0.pcm_in_valid[1] = 1'b1;
            bus0.pcm_in[31:16]   = 16'h0100 + 16'(i);
            @(negedge pcm_clk);
        end
        bus0.pcm_in_valid[1] = 1'b0;
        repeat (3) @(negedge pcm_clk);
        reg_read(0, 16'hF001, d, t);
        checks++;
        if (d !== 32'h0002_0001) begin errors++; $display("FAIL gap_status: got %h required 00020001", d); end
        bus0.pcm_in_valid[1] = 1'b1;
        bus0.pcm_in[31:16]   = 16'h0103;
        @(negedge pcm_clk);
        bus0.pcm_in_valid[1] = 1'b0;
        reg_read(0, 16'hF001, d, t);
        checks++;
        if (d !== 32'h0003_0001) begin errors++; $display("FAIL resume_status: got %h required 00030001", d); end
        reg_read(0, 16'h1000, d, t);
        checks++;
        if (d !== 32'h0102_0101) begin errors++; $display("FAIL ch1_word0: got %h required 01020101", d); end
    endtask

    task automatic test_arm_clear();
        logic [31:0] d;
        bit          t;
        reg_write(0, 16'hF001, 32'h3);
        reg_read(0, 16'hF001, d, t);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL arm_clear_status: got %h required 00000000", d); end
        reg_write(0, 16'hF002, 32'h1);
        reg_read(0, 16'hF002, d, t);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL arm_len0_status: got %h required 00000000", d); end
    endtask

    task automatic test_reset_midcapture();
        logic [31:0] d;
        bit          t;
        reg_write(0, 16'hF000, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            bus0.pcm_in_valid[0] = 1'b1;
            bus0.pcm_in[15:0]    = 16'h0010 + 16'(i);
            @(negedge pcm_clk);
        end
        bus0.pcm_in_valid[0] = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge pcm_clk);
        rst = 1'b0;
        checks++;
        if (done0 !== 3'b000) begin errors++; $display("FAIL midreset_done: got %b required 000", done0); end
        for (int k = 0; k < 3; k++) begin
            reg_read(0, 16'hF000 + 16'(k), d, t);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL midreset_status%0d: got %h required 00000000", k, d); end
        end
        reg_read(0, 16'h0000, d, t);
        checks++;
        if (d !== 32'h0012_0011) begin errors++; $display("FAIL midreset_word0: got %h required 00120011", d); end
        reg_read(0, 16'h0001, d, t);
        checks++;
        if (d !== 32'h0014_0013) begin errors++; $display("FAIL midreset_word1: got %h required 00140013", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        bit          t;
        reg_read(0, 16'hF005, d, t);
        checks++;
        if (d !== 32'h0 || !t) begin errors++; $display("FAIL ctrl_word5: got %h timing %0d required 00000000 timing 1", d, t); end
        reg_read(0, 16'h0200, d, t);
        checks++;
        if (d !== 32'h0 || !t) begin errors++; $display("FAIL mem_0200: got %h timing %0d required 00000000 timing 1", d, t); end
    endtask

    task automatic test_two_channels();
        logic [31:0] d;
        bit          t;
        logic [15:0] a_tab [6];
        logic [31:0] e_tab [6];
        a_tab = '{16'h0000, 16'h0001, 16'h0002, 16'h2000, 16'h2001, 16'h2002};
        e_tab = '{32'hA002_A001, 32'hA004_A003, 32'h0006_0015,
                  32'hC002_C001, 32'hC004_C003, 32'hC006_C005};
        cap_len0[9:0]   = 10'd4;
        cap_len0[29:20] = 10'd6;
        reg_write(0, 16'hF000, 32'h1);
        reg_write(0, 16'hF002, 32'h1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge pcm_clk);
            bus0.pcm_in_valid[0] = 1'b1;
            bus0.pcm_in_valid[2] = 1'b1;
            bus0.pcm_in[15:0]    = 16'hA000 + 16'(i);
            bus0.pcm_in[47:32]   = 16'hC000 + 16'(i);
            @(posedge pcm_clk); #1;
            checks++;
            if ({done0[2], done0[0]} !== {(i >= 6), (i >= 4)}) begin
                errors++;
                $display("FAIL dual_done_edge%0d: got ch2=%b ch0=%b required ch2=%b ch0=%b",
                         i, done0[2], done0[0], (i >= 6), (i >= 4));
            end
        end
        @(negedge pcm_clk);
        bus0.pcm_in_valid = '0;
        for (int n = 0; n < 6; n++) begin
            reg_read(0, a_tab[n], d, t);
            checks++;
            if (d !== e_tab[n]) begin errors++; $display("FAIL dual_word %h: got %h required %h", a_tab[n], d, e_tab[n]); end
        end
    endtask

    task automatic test_drop_idle();
        logic [31:0] d;
        bit          t;
        @(negedge pcm_clk);
        bus1.pcm_in_valid[0] = 1'b1;
        bus1.pcm_in[15:0]    = 16'h7777;
        #1;
        checks++;
        if (bus1.pcm_in_ready[0] !== 1'b1) begin errors++; $display("FAIL drop_idle_ready: got %b required 1", bus1.pcm_in_ready[0]); end
        repeat (3) @(negedge pcm_clk);
        bus1.pcm_in_valid[0] = 1'b0;
        reg_read(1, 16'hF000, d, t);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL drop_idle_status: got %h required 00000000", d); end
        reg_write(1, 16'hF000, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            bus1.pcm_in_valid[0] = 1'b1;
            bus1.pcm_in[15:0]    = 16'(i);
            @(posedge pcm_clk); #1;
            checks++;
            if (done1[0] !== (i == 4)) begin errors++; $display("FAIL drop_done_edge%0d: got %b required %b", i, done1[0], (i == 4)); end
            @(negedge pcm_clk);
        end
        bus1.pcm_in_valid[0] = 1'b0;
        checks++;
        if (bus1.pcm_in_ready[0] !== 1'b1) begin errors++; $display("FAIL drop_done_ready: got %b required 1", bus1.pcm_in_ready[0]); end
        reg_read(1, 16'h0000, d, t);
        checks++;
        if (d !== 32'h0002_0001) begin errors++; $display("FAIL drop_word0: got %h required 00020001", d); end
        reg_read(1, 16'h0001, d, t);
        checks++;
        if (d !== 32'h0004_0003) begin errors++; $display("FAIL drop_word1: got %h required 00040003", d); end
    endtask

    initial begin
        bus0.pcm_in_valid = '0; bus0.pcm_in = '0;
        bus1.pcm_in_valid = '0; bus1.pcm_in = '0;
        bus_set(0, 16'h0, 1'b0, 1'b0, 32'h0);
        bus_set(1, 16'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_capture();
        test_ready_gating();
        test_arm_clear();
        test_reset_midcapture();
        test_out_of_range();
        test_two_channels();
        test_drop_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
